ara_w_golden_checker: RTL and testbench
=======================================

Name: ara_w_golden_checker

Overview:
- Synthesizable/simulation checker that snoops the vector store AXI W channel (data, strobe, valid, ready) and compares every strobe-enabled byte, in order, against a golden byte stream.
- The golden stream is fed through a valid/ready port. It is the reading counterpart of the per-byte store dump.
- Sits in the testbench harness next to the VLSU or cluster W port. It flags mismatches, counts bytes and records the first failure.

Parameters:
- DataWidth, 128, W-channel data width in bits (multiple of 8).
- FifoDepth, 4, snooped-beat buffer depth (power of 2, >=2).
- CntWidth, 32, width of the byte and mismatch counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- w_data_i  in  DataWidth  snooped W data.
- w_strb_i  in  DataWidth/8  snooped W strobe.
- w_valid_i  in  1  snooped W valid.
- w_ready_i  in  1  snooped W ready.
- dump_en_i  in  1  capture enable (measurement window mask).
- gold_byte_i  in  8  expected byte.
- gold_valid_i  in  1  expected byte valid.
- gold_ready_o  out  1  expected byte consumed.
- byte_cnt_o  out  CntWidth  bytes compared.
- mismatch_cnt_o  out  CntWidth  mismatching bytes.
- first_idx_o  out  CntWidth  byte index of the first mismatch.
- first_exp_o  out  8  expected value at the first mismatch.
- first_got_o  out  8  observed value at the first mismatch.
- error_o  out  1  sticky: any mismatch.
- overflow_o  out  1  sticky: beat lost because the FIFO was full.
- idle_o  out  1  no beat buffered or in progress.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - All counters and first_* outputs are 0; error_o=0, overflow_o=0.
  - The FIFO is flushed, the FSM goes to IDLE, idle_o=1 and gold_ready_o=0.
  - Reset mid-operation discards any buffered or partially checked beat.
- Capture:
  - When w_valid_i & w_ready_i & dump_en_i, the beat {data, strb} is pushed at that edge.
  - The checker never backpressures the snooped channel.
  - A push into a full FIFO with no simultaneous pop sets overflow_o and drops the beat.
  - A push and pop in the same cycle on a full FIFO is accepted.
- Working register holds {data, mask}, where mask is the remaining strobes.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the working register and go to CHECK. Latency is 1 cycle from push to working register when idle.
  - CHECK, byte selection: sel = lowest set bit of mask (priority encoder); gold_ready_o = (mask != 0).
  - CHECK, on gold_valid_i & gold_ready_o: compare data[8*sel +: 8] with gold_byte_i, clear mask[sel] and increment byte_cnt_o.
  - CHECK, on a compare mismatch: increment mismatch_cnt_o. If error_o was 0, capture first_idx_o = byte_cnt_o (pre-increment value), first_exp_o and first_got_o, then set error_o.
  - CHECK, beat completion: when the next mask is 0 (last byte consumed, or an all-zero-strobe beat), pop the next beat directly if the FIFO is non-empty, else go to IDLE. An all-zero-strobe beat costs 1 cycle.
- Throughput is one byte per cycle.
- Counters saturate at all-ones; they do not wrap.
- Golden bytes presented while no beat is in progress are not consumed.
- idle_o = (state==IDLE) & FIFO empty.

Optional Feature:
- Macro ARA_W_GOLDEN_CHECK_TRACE_EN.
- Defined: every mismatch issues a simulation $display with byte index, expected and observed value; an overflow issues a $warning once.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Decomposition:
- Package ara_w_check_pkg holds:
  - beat_t {data, strb} typedef;
  - state_e {IDLE, CHECK};
  - the saturating-increment helper function.
- One sub-module, ara_w_beat_fifo:
  - FifoDepth entries of beat_t, with push/pop/full/empty;
  - same-cycle push+pop supported when full;
  - flushed by rst_i.

Test Plan:
- Single beat, strb=16'hFFFF, data bytes 0x00..0x0F, gold 0x00..0x0F → byte_cnt=16, mismatch_cnt=0, error_o=0, idle_o=1 after 17 cycles.
- Sparse strobe 16'h8001 with data[7:0]=0xAA, data[127:120]=0xBB; gold AA,BB → exactly 2 golden bytes consumed in 2 cycles; byte_cnt=2.
- Mismatch: gold 3rd byte 0x55, observed 0x56 → error_o=1, first_idx=2, first_exp=0x55, first_got=0x56. A later mismatch increments mismatch_cnt to 2 but first_* are unchanged.
- Overflow: 6 back-to-back full-strobe beats with gold_valid_i=0 → 1 beat in the working register, 4 in the FIFO, the 6th sets overflow_o=1. Beats with dump_en_i=0 are ignored.
- Zero-strobe beat between two full beats → takes 1 cycle; the golden stream stays contiguous; byte_cnt=32.
- Assert rst_i while in CHECK with 5 bytes outstanding → next cycle all outputs are 0, idle_o=1, and no golden byte is consumed.

Source files
------------

// File: rtl/ara_w_check_pkg.sv
// Shared types and helpers for the W-channel golden checker: the snooped beat,
// the checker FSM states and the saturating counter increment.
package ara_w_check_pkg;

    localparam int unsigned BEAT_DATA_W = 128;
    localparam int unsigned CNT_W       = 32;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]   data;
        logic [BEAT_DATA_W/8-1:0] strb;
    } beat_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ara_w_beat_fifo.sv
// Small buffer of snooped W beats between the capture point and the byte checker.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ara_w_beat_fifo
    import ara_w_check_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  beat_t push_beat_i,
    input  logic  pop_i,
    output beat_t head_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    beat_t           mem_r [Depth];
    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    logic [PtrW:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign empty_o   = (count_r == {(PtrW+1){1'b0}});
    assign full_o    = (count_r == (PtrW+1)'(Depth));
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign head_o    = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; reset flushes the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {(PtrW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{PtrW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PtrW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Beat storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_beat_i;
    end

endmodule

// File: rtl/ara_w_golden_checker.sv
// Snoops the vector store W channel and compares every strobed byte, in order,
// against a golden byte stream. Define ARA_W_GOLDEN_CHECK_TRACE_EN for simulation reporting.
module ara_w_golden_checker
    import ara_w_check_pkg::*;
#(
    parameter int unsigned DataWidth = BEAT_DATA_W,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned CntWidth  = CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    input  logic                   w_ready_i,
    input  logic                   dump_en_i,
    input  logic [7:0]             gold_byte_i,
    input  logic                   gold_valid_i,
    output logic                   gold_ready_o,
    output logic [CntWidth-1:0]    byte_cnt_o,
    output logic [CntWidth-1:0]    mismatch_cnt_o,
    output logic [CntWidth-1:0]    first_idx_o,
    output logic [7:0]             first_exp_o,
    output logic [7:0]             first_got_o,
    output logic                   error_o,
    output logic                   overflow_o,
    output logic                   idle_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned SelW  = $clog2(StrbW);

    state_e               state_r;
    logic [DataWidth-1:0] data_r;
    logic [StrbW-1:0]     mask_r;
    logic [StrbW-1:0]     mask_next_s;
    logic [SelW-1:0]      sel_s;
    logic [7:0]           got_s;
    logic                 consume_s;
    logic                 mismatch_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 overflow_evt_s;
    beat_t                push_beat_s;
    beat_t                head_s;
    logic [CntWidth-1:0]  byte_cnt_r;
    logic [CntWidth-1:0]  mismatch_cnt_r;
    logic [CntWidth-1:0]  first_idx_r;
    logic [7:0]           first_exp_r;
    logic [7:0]           first_got_r;
    logic                 error_r;
    logic                 overflow_r;

    assign push_s           = w_valid_i & w_ready_i & dump_en_i;
    assign push_beat_s.data = w_data_i;
    assign push_beat_s.strb = w_strb_i;
    assign overflow_evt_s   = push_s & full_s & ~pop_s;

    ara_w_beat_fifo #(
        .Depth(FifoDepth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_s),
        .push_beat_i(push_beat_s),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .full_o     (full_s),
        .empty_o    (empty_s)
    );

    // Priority encoder: the lowest remaining strobe is the next byte to check.
    always_comb begin
        sel_s = {SelW{1'b0}};
        for (int i = StrbW - 1; i >= 0; i--) begin
            sel_s = mask_r[i] ? SelW'(i) : sel_s;
        end
    end

    assign got_s        = data_r[{sel_s, 3'b000} +: 8];
    assign gold_ready_o = (state_r == CHECK) & (|mask_r);
    assign consume_s    = gold_valid_i & gold_ready_o;
    assign mismatch_s   = consume_s & (got_s != gold_byte_i);

    // Remaining strobes after this cycle's compare.
    always_comb begin
        mask_next_s = mask_r;
        if (consume_s) begin
            mask_next_s[sel_s] = 1'b0;
        end else begin
            mask_next_s = mask_r;
        end
    end

    // A beat finishing (including an all-zero-strobe beat) hands straight over to the next one.
    assign pop_s = ~empty_s & ((state_r == IDLE) | (mask_next_s == {StrbW{1'b0}}));

    // Working register, FSM, counters and first-failure capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            data_r         <= {DataWidth{1'b0}};
            mask_r         <= {StrbW{1'b0}};
            byte_cnt_r     <= {CntWidth{1'b0}};
            mismatch_cnt_r <= {CntWidth{1'b0}};
            first_idx_r    <= {CntWidth{1'b0}};
            first_exp_r    <= 8'h00;
            first_got_r    <= 8'h00;
            error_r        <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            if (overflow_evt_s) overflow_r <= 1'b1;
            if (consume_s) byte_cnt_r <= sat_inc(byte_cnt_r);
            if (mismatch_s) begin
                mismatch_cnt_r <= sat_inc(mismatch_cnt_r);
                if (!error_r) begin
                    first_idx_r <= byte_cnt_r;
                    first_exp_r <= gold_byte_i;
                    first_got_r <= got_s;
                    error_r     <= 1'b1;
                end
            end
            if (pop_s) begin
                data_r  <= head_s.data;
                mask_r  <= head_s.strb;
                state_r <= CHECK;
            end else if ((state_r == CHECK) && (mask_next_s == {StrbW{1'b0}})) begin
                mask_r  <= {StrbW{1'b0}};
                state_r <= IDLE;
            end else begin
                mask_r  <= mask_next_s;
            end
        end
    end

    assign byte_cnt_o     = byte_cnt_r;
    assign mismatch_cnt_o = mismatch_cnt_r;
    assign first_idx_o    = first_idx_r;
    assign first_exp_o    = first_exp_r;
    assign first_got_o    = first_got_r;
    assign error_o        = error_r;
    assign overflow_o     = overflow_r;
    assign idle_o         = (state_r == IDLE) & empty_s;

`ifdef ARA_W_GOLDEN_CHECK_TRACE_EN
    // Simulation-only reporting of each compare failure and of the first dropped beat.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mismatch_s) begin
            $display("ara_w_golden_checker: byte %0d expected %02h observed %02h",
                     byte_cnt_r, gold_byte_i, got_s);
        end
        if (!rst_i && overflow_evt_s && !overflow_r) begin
            $warning("ara_w_golden_checker: beat dropped, snoop buffer full");
        end
    end
`endif

endmodule

// File: tb/tb_ara_w_golden_checker.sv
// Directed and randomized bench for ara_w_golden_checker; expected results come
// from a byte-stream model (captured strobed bytes vs. the golden queue).
module tb_ara_w_golden_checker;

    localparam int DW = 128;
    localparam int SW = DW / 8;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] w_data_i = '0;
    logic [SW-1:0] w_strb_i = '0;
    logic          w_valid_i = 1'b0;
    logic          w_ready_i = 1'b0;
    logic          dump_en_i = 1'b0;
    logic [7:0]    gold_byte_i = 8'h00;
    logic          gold_valid_i = 1'b0;
    logic          gold_ready_o;
    logic [CW-1:0] byte_cnt_o, mismatch_cnt_o, first_idx_o;
    logic [7:0]    first_exp_o, first_got_o;
    logic          error_o, overflow_o, idle_o;

    int total = 0;
    int bad   = 0;

    // Model state: bytes the checker should see, golden bytes offered, bytes handed over.
    byte unsigned obs_q[$];
    byte unsigned gold_q[$];
    int           gidx = 0;
    bit           hs = 1'b0;
    int           gold_mode = 0;   // 0 off, 1 always valid, 2 random valid

    always #5 clk_i = ~clk_i;

    ara_w_golden_checker dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_i(w_ready_i),
        .dump_en_i(dump_en_i), .gold_byte_i(gold_byte_i), .gold_valid_i(gold_valid_i),
        .gold_ready_o(gold_ready_o), .byte_cnt_o(byte_cnt_o), .mismatch_cnt_o(mismatch_cnt_o),
        .first_idx_o(first_idx_o), .first_exp_o(first_exp_o), .first_got_o(first_got_o),
        .error_o(error_o), .overflow_o(overflow_o), .idle_o(idle_o)
    );

    // Golden source: offers gold_q[gidx] and advances once a handshake has happened.
    always begin
        @(negedge clk_i);
        #2;
        if (hs) gidx++;
        gold_valid_i = 1'b0;
        gold_byte_i  = 8'h00;
        if (gold_mode != 0 && gidx < gold_q.size()) begin
            gold_valid_i = (gold_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            gold_byte_i  = gold_q[gidx];
        end
        hs = gold_valid_i & gold_ready_o & ~rst_i;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        gold_mode = 0;
        w_valid_i = 1'b0;
        rst_i     = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #4;
        obs_q.delete();
        gold_q.delete();
        gidx = 0;
        hs   = 1'b0;
    endtask

    // Drive one beat for one cycle; bytes flagged in bad get a corrupted golden copy.
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit en,
                             input bit rdy, input bit keep, input logic [SW-1:0] bad_m,
                             input logic [7:0] flip);
        w_data_i  = d;
        w_strb_i  = s;
        w_valid_i = 1'b1;
        w_ready_i = rdy;
        dump_en_i = en;
        if (en && rdy && keep) begin
            for (int b = 0; b < SW; b++) begin
                if (s[b]) begin
                    obs_q.push_back(d[8*b +: 8]);
                    gold_q.push_back(bad_m[b] ? (d[8*b +: 8] ^ flip) : d[8*b +: 8]);
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(idle_o && gidx == gold_q.size()) && n < 3000) begin
            @(negedge clk_i);
            #4;
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    // Expected counters and first failure follow from comparing the two byte streams.
    task automatic check_model(input string tag);
        int  mis = 0;
        int  fi  = 0;
        bit  err = 1'b0;
        byte unsigned fe = 0, fg = 0;
        chk({tag, "_gold_used"}, 64'(gidx), 64'(gold_q.size()));
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i] != gold_q[i]) begin
                if (!err) begin
                    err = 1'b1; fi = i; fe = gold_q[i]; fg = obs_q[i];
                end
                mis++;
            end
        end
        chk({tag, "_byte_cnt"}, 64'(byte_cnt_o), 64'(obs_q.size()));
        chk({tag, "_mis_cnt"}, 64'(mismatch_cnt_o), 64'(mis));
        chk({tag, "_error"}, 64'(error_o), 64'(err));
        chk({tag, "_first_idx"}, 64'(first_idx_o), 64'(fi));
        chk({tag, "_first_exp"}, 64'(first_exp_o), 64'(fe));
        chk({tag, "_first_got"}, 64'(first_got_o), 64'(fg));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int            g0;

        // Reset state
        do_reset();
        chk("rst_byte_cnt", 64'(byte_cnt_o), 64'd0);
        chk("rst_mis_cnt", 64'(mismatch_cnt_o), 64'd0);
        chk("rst_first_idx", 64'(first_idx_o), 64'd0);
        chk("rst_first_exp", 64'(first_exp_o), 64'd0);
        chk("rst_first_got", 64'(first_got_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_gold_ready", 64'(gold_ready_o), 64'd0);

        // Single full beat, bytes 0x00..0x0F: last byte lands 17 cycles after the push
        for (int b = 0; b < SW; b++) d[8*b +: 8] = 8'(b);
        gold_mode = 1;
        send_beat(d, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        w_valid_i = 1'b0;
        repeat (16) @(negedge clk_i);
        #4;
        chk("full_cnt_n17", 64'(byte_cnt_o), 64'd15);
        chk("full_idle_n17", 64'(idle_o), 64'd0);
        @(negedge clk_i);
        #4;
        chk("full_cnt_n18", 64'(byte_cnt_o), 64'd16);
        chk("full_idle_n18", 64'(idle_o), 64'd1);
        check_model("full");

        // Sparse strobe 16'h8001: two golden bytes in two cycles
        d = {$urandom, $urandom, $urandom, $urandom};
        d[7:0]     = 8'hAA;
        d[127:120] = 8'hBB;
        send_beat(d, 16'h8001, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        w_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #4;
        chk("sparse_cnt_1st", 64'(byte_cnt_o), 64'd17);
        @(negedge clk_i);
        #4;
        chk("sparse_cnt_2nd", 64'(byte_cnt_o), 64'd18);
        chk("sparse_idle", 64'(idle_o), 64'd1);
        check_model("sparse");

        // Mismatches at byte 2 (gold 0x55 vs 0x56) and byte 7; first_* keep the first one
        do_reset();
        for (int b = 0; b < SW; b++) d[8*b +: 8] = 8'(8'h54 + b);
        gold_mode = 1;
        send_beat(d, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0084, 8'h03);
        w_valid_i = 1'b0;
        wait_done("mism");
        chk("mism_first_idx", 64'(first_idx_o), 64'd2);
        chk("mism_first_exp", 64'(first_exp_o), 64'h55);
        chk("mism_first_got", 64'(first_got_o), 64'h56);
        chk("mism_cnt", 64'(mismatch_cnt_o), 64'd2);
        check_model("mism");

        // Zero-strobe beat between two full beats costs exactly one cycle
        do_reset();
        gold_mode = 1;
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        w_valid_i = 1'b0;
        repeat (31) @(negedge clk_i);
        #4;
        chk("zero_cnt_n34", 64'(byte_cnt_o), 64'd31);
        chk("zero_idle_n34", 64'(idle_o), 64'd0);
        @(negedge clk_i);
        #4;
        chk("zero_cnt_n35", 64'(byte_cnt_o), 64'd32);
        chk("zero_idle_n35", 64'(idle_o), 64'd1);
        check_model("zero");

        // Overflow: masked beats ignored, then six back-to-back beats with no golden data
        do_reset();
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        w_valid_i = 1'b0;
        @(negedge clk_i);
        #4;
        chk("ovf_masked_idle", 64'(idle_o), 64'd1);
        for (int k = 0; k < 6; k++) begin
            send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 1'b1, k < 5, 16'h0000, 8'h00);
            if (k == 4) chk("ovf_before_6th", 64'(overflow_o), 64'd0);
        end
        w_valid_i = 1'b0;
        chk("ovf_after_6th", 64'(overflow_o), 64'd1);
        chk("ovf_busy", 64'(idle_o), 64'd0);
        gold_mode = 1;
        wait_done("ovf");
        chk("ovf_sticky", 64'(overflow_o), 64'd1);
        chk("ovf_five_beats", 64'(byte_cnt_o), 64'd80);
        check_model("ovf");

        // Reset while five bytes of a beat are still outstanding
        do_reset();
        gold_mode = 1;
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        w_valid_i = 1'b0;
        repeat (5) begin
            void'(gold_q.pop_back());
            void'(obs_q.pop_back());
        end
        begin
            int n = 0;
            while (gidx < 11 && n < 200) begin
                @(negedge clk_i);
                #4;
                n++;
            end
        end
        chk("mid_cnt", 64'(byte_cnt_o), 64'd11);
        chk("mid_gold_ready", 64'(gold_ready_o), 64'd1);
        g0 = gidx;
        for (int k = 0; k < 5; k++) gold_q.push_back(8'($urandom));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #4;
        chk("mid_rst_cnt", 64'(byte_cnt_o), 64'd0);
        chk("mid_rst_mis", 64'(mismatch_cnt_o), 64'd0);
        chk("mid_rst_error", 64'(error_o), 64'd0);
        chk("mid_rst_idle", 64'(idle_o), 64'd1);
        chk("mid_rst_ready", 64'(gold_ready_o), 64'd0);
        repeat (3) @(negedge clk_i);
        #4;
        chk("mid_rst_no_consume", 64'(gidx), 64'(g0));
        chk("mid_rst_cnt_later", 64'(byte_cnt_o), 64'd0);

        // Randomized bursts of at most five beats, random golden pacing and corruption
        do_reset();
        gold_mode = 2;
        for (int burst = 0; burst < 10; burst++) begin
            int nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       s = 16'hFFFF;
                    1:       s = 16'h0000;
                    default: s = 16'($urandom);
                endcase
                send_beat(d, s, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), 1'b1,
                          16'($urandom & $urandom & $urandom), 8'($urandom_range(1, 255)));
            end
            w_valid_i = 1'b0;
            wait_done("rand");
        end
        chk("rand_no_overflow", 64'(overflow_o), 64'd0);
        check_model("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
